// File: rtl/db_fsm_if.sv
// Signal bundle between a switch debouncer and its user: the tick and raw switch go in,
// the debounced level and edge pulses come out.
interface db_fsm_if;
    logic tick;
    logic sw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    modport master (
        output tick,
        output sw_in,
        input  db_level,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  tick,
        input  sw_in,
        output db_level,
        output db_rise,
        output db_fall
    );
endinterface

// File: rtl/db_fsm.sv
// Switch debouncer: two-flop synchronizer followed by a ZERO/WAIT1/ONE/WAIT0 FSM that
// only accepts a new level after it has stayed stable for STABLE_TICKS tick pulses.
module db_fsm #(
    parameter int STABLE_TICKS = 3
) (
    input  logic     clk,
    input  logic     rst,
    db_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(STABLE_TICKS - 1);

    logic   sync1_q, sync2_q;
    logic   sw_s;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic   rise_q, rise_d;
    logic   fall_q, fall_d;

    assign sw_s = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= 4'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= bus.sw_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Entering a WAIT state clears cnt, so a tick in the entry cycle is never counted.
    // A level change on sw_s is checked before tick, so bounce always wins over a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = 4'd0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                    cnt_d   = 4'd0;
                end else if (bus.tick) begin
                    if (cnt_q >= LAST_CNT) begin
                        state_d = ONE;
                        cnt_d   = 4'd0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = 4'd0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                    cnt_d   = 4'd0;
                end else if (bus.tick) begin
                    if (cnt_q >= LAST_CNT) begin
                        state_d = ZERO;
                        cnt_d   = 4'd0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign bus.db_level = (state_q == ONE) || (state_q == WAIT0);
    assign bus.db_rise  = rise_q;
    assign bus.db_fall  = fall_q;

endmodule

// File: tb/tb_db_fsm.sv
// Directed bench for db_fsm: one instance with STABLE_TICKS=3 and one with STABLE_TICKS=1,
// sharing clock, reset and a tick pulse every 10 clocks.
module tb_db_fsm;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic sw3;
    logic sw1;

    always #5 clk = ~clk;

    db_fsm_if ifc3 ();
    db_fsm_if ifc1 ();

    assign ifc3.tick  = tick;
    assign ifc3.sw_in = sw3;
    assign ifc1.tick  = tick;
    assign ifc1.sw_in = sw1;

    db_fsm #(.STABLE_TICKS(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3.slave)
    );

    db_fsm #(.STABLE_TICKS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc   = 0;
    int phase = 0;
    int start_cyc;
    int both_n = 0;
    // Observation window for the ST=3 instance
    logic base3;
    int   rise3_n, fall3_n, chg3, first_rise3, first_fall3;
    // Observation window for the ST=1 instance
    logic base1;
    int   rise1_n, fall1_n, chg1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_window();
        start_cyc   = cyc;
        base3       = ifc3.db_level;
        rise3_n     = 0;
        fall3_n     = 0;
        chg3        = -1;
        first_rise3 = -1;
        first_fall3 = -1;
        base1       = ifc1.db_level;
        rise1_n     = 0;
        fall1_n     = 0;
        chg1        = -1;
    endtask

    // Each iteration samples outputs on the falling edge, then sets tick for the next rising edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (ifc3.db_rise) begin
                rise3_n++;
                if (first_rise3 < 0) first_rise3 = cyc - start_cyc;
            end
            if (ifc3.db_fall) begin
                fall3_n++;
                if (first_fall3 < 0) first_fall3 = cyc - start_cyc;
            end
            if (ifc3.db_level != base3 && chg3 < 0) chg3 = cyc - start_cyc;
            if (ifc3.db_rise && ifc3.db_fall) both_n++;
            if (ifc1.db_rise) rise1_n++;
            if (ifc1.db_fall) fall1_n++;
            if (ifc1.db_level != base1 && chg1 < 0) chg1 = cyc - start_cyc;
            if (ifc1.db_rise && ifc1.db_fall) both_n++;
            tick  = (phase == 9);
            phase = (phase + 1) % 10;
        end
    endtask

    // Returns right after the iteration that armed a tick, so the next rising edge carries a tick.
    task automatic align();
        run_cycles(1);
        while (phase != 0) run_cycles(1);
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        sw3  = 1'b0;
        sw1  = 1'b0;
        clear_window();
        run_cycles(3);
        check_eq("reset_level", int'(ifc3.db_level), 0);
        check_eq("reset_rise",  int'(ifc3.db_rise), 0);
        check_eq("reset_fall",  int'(ifc3.db_fall), 0);
        check_eq("reset_level_st1", int'(ifc1.db_level), 0);
        rst = 1'b0;
        run_cycles(5);

        // Clean press: WAIT1 at edge 3, ticks counted at edges 11, 21, 31
        align();
        clear_window();
        sw3 = 1'b1;
        run_cycles(40);
        check_eq("press_level",      int'(ifc3.db_level), 1);
        check_eq("press_change_cyc", chg3, 31);
        check_eq("press_rise_cyc",   first_rise3, 31);
        check_eq("press_rise_width", rise3_n, 1);
        check_eq("press_no_fall",    fall3_n, 0);

        // Release from ONE
        align();
        clear_window();
        sw3 = 1'b0;
        run_cycles(40);
        check_eq("release_level",      int'(ifc3.db_level), 0);
        check_eq("release_change_cyc", chg3, 31);
        check_eq("release_fall_cyc",   first_fall3, 31);
        check_eq("release_fall_width", fall3_n, 1);
        check_eq("release_no_rise",    rise3_n, 0);

        // Bounce 1,0,1,0,1 at 7-clk spacing; the last WAIT1 entry coincides with a tick at edge 31
        align();
        clear_window();
        sw3 = 1'b1; run_cycles(7);
        sw3 = 1'b0; run_cycles(7);
        sw3 = 1'b1; run_cycles(7);
        sw3 = 1'b0; run_cycles(7);
        sw3 = 1'b1; run_cycles(45);
        check_eq("bounce_change_cyc", chg3, 61);
        check_eq("bounce_rise_count", rise3_n, 1);
        check_eq("bounce_level",      int'(ifc3.db_level), 1);

        // Asynchronous reset while in ONE, released with sw_in still high
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_level", int'(ifc3.db_level), 0);
        check_eq("async_rst_rise",  int'(ifc3.db_rise), 0);
        check_eq("async_rst_fall",  int'(ifc3.db_fall), 0);
        run_cycles(2);
        align();
        rst = 1'b0;
        clear_window();
        run_cycles(40);
        check_eq("rst_release_change_cyc", chg3, 31);
        check_eq("rst_release_rise_cyc",   first_rise3, 31);
        check_eq("rst_release_rise_count", rise3_n, 1);

        align();
        clear_window();
        sw3 = 1'b0;
        run_cycles(40);
        check_eq("release2_level", int'(ifc3.db_level), 0);

        // sw_s drops in the very cycle of the third WAIT1 tick (edge 31)
        align();
        clear_window();
        sw3 = 1'b1; run_cycles(28);
        sw3 = 1'b0; run_cycles(40);
        check_eq("simul_no_change", chg3, -1);
        check_eq("simul_no_rise",   rise3_n, 0);
        check_eq("simul_level",     int'(ifc3.db_level), 0);

        // Reset after two counted ticks in WAIT1 (edges 11 and 21)
        align();
        clear_window();
        sw3 = 1'b1;
        run_cycles(25);
        check_eq("midwait_pre_level", int'(ifc3.db_level), 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midwait_rst_level", int'(ifc3.db_level), 0);
        check_eq("midwait_rst_rise",  int'(ifc3.db_rise), 0);
        run_cycles(2);
        align();
        rst = 1'b0;
        clear_window();
        run_cycles(40);
        check_eq("midwait_release_change_cyc", chg3, 31);
        check_eq("midwait_release_rise_count", rise3_n, 1);

        // STABLE_TICKS=1: first counted tick after WAIT1 entry is edge 11
        align();
        clear_window();
        sw1 = 1'b1;
        run_cycles(20);
        check_eq("st1_press_change_cyc", chg1, 11);
        check_eq("st1_press_rise_count", rise1_n, 1);
        check_eq("st1_press_level",      int'(ifc1.db_level), 1);
        align();
        clear_window();
        sw1 = 1'b0;
        run_cycles(20);
        check_eq("st1_release_change_cyc", chg1, 11);
        check_eq("st1_release_fall_count", fall1_n, 1);
        check_eq("st1_release_no_rise",    rise1_n, 0);

        check_eq("rise_fall_never_together", both_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/db_fsm.md
DB_FSM -- requirements
Module: db_fsm

Interface
REQ-001 SHALL have parameter STABLE_TICKS, default 3, meaning the number of consecutive tick pulses the synchronized input must stay stable before the output changes; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tick, input, 1, one-clk-wide enable pulse from the 1,000,000-cycle tick generator.
REQ-005 SHALL have port sw_in, input, 1, raw, asynchronous, bouncing switch or button level.
REQ-006 SHALL have port db_level, output, 1, debounced level.
REQ-007 SHALL have port db_rise, output, 1, one-clk pulse when db_level goes 0->1.
REQ-008 SHALL have port db_fall, output, 1, one-clk pulse when db_level goes 1->0.

Function
REQ-009 SHALL pass sw_in through a two-flop synchronizer; sw_s is the second flop, so latency from sw_in to sw_s is 2 clk edges.
REQ-010 SHALL implement a 4-state FSM: ZERO, WAIT1, ONE, WAIT0.
REQ-011 SHALL keep a 4-bit tick counter cnt, used only in WAIT1 and WAIT0.
REQ-012 ZERO: when sw_s=1, SHALL go to WAIT1 with cnt<=0; otherwise SHALL stay in ZERO.
REQ-013 WAIT1, sw_s=0: SHALL return to ZERO; this check has priority over tick.
REQ-014 WAIT1, sw_s=1 and tick=1, cnt==STABLE_TICKS-1: SHALL go to ONE and set db_rise for the next cycle.
REQ-015 WAIT1, sw_s=1 and tick=1, cnt<STABLE_TICKS-1: SHALL increment cnt.
REQ-016 WAIT1, sw_s=1 and tick=0: SHALL hold state and cnt.
REQ-017 ONE: when sw_s=0, SHALL go to WAIT0 with cnt<=0; otherwise SHALL stay in ONE.
REQ-018 WAIT0: SHALL mirror WAIT1 with polarities swapped.
  - sw_s=1 returns to ONE.
  - The qualifying tick at cnt==STABLE_TICKS-1 goes to ZERO and sets db_fall.
REQ-019 SHALL drive db_level=1 exactly when state is ONE or WAIT0, decoded combinationally from the state register.
REQ-020 db_rise and db_fall SHALL be registered, each high for exactly the first clk cycle of the new state, and never high together.
REQ-021 A tick arriving in the same cycle as a ZERO->WAIT1 or ONE->WAIT0 transition SHALL NOT be counted.
  - Required stable time after sw_s settles is STABLE_TICKS full tick intervals, minus up to one interval.
REQ-022 Any bounce of sw_s during a WAIT state SHALL abort the wait with no output change and no pulse.
REQ-023 cnt SHALL never exceed STABLE_TICKS-1; unused state encodings SHALL recover to ZERO on the next clk edge.

Reset
REQ-024 rst=1 SHALL immediately force the following, regardless of clk:
  - both synchronizer flops = 0
  - state = ZERO, cnt = 0
  - db_level = 0, db_rise = 0, db_fall = 0
REQ-025 Reset asserted mid-wait (WAIT1 or WAIT0) SHALL discard the partial count.
  - After release, the block SHALL require a full new stable period before any output change.
REQ-026 After rst deasserts with sw_in=1, the first db_rise SHALL occur only after the normal synchronize-and-wait sequence; no pulse is emitted at reset release.

Verification
REQ-027 Clean press: bench drives tick every 10 clks, STABLE_TICKS=3, sw_in 0->1 and held -> db_level rises after 3 ticks counted in WAIT1 (20-30 clks after sw_s=1), with db_rise high exactly 1 clk.
REQ-028 Bounce: sw_in toggles 1,0,1,0,1 at 7-clk spacing, then holds 1 -> no db_level change during toggling; single db_rise after 3 stable ticks.
REQ-029 Release: from ONE, sw_in 1->0 held -> db_level falls after 3 ticks; db_fall high 1 clk; db_rise stays 0.
REQ-030 Simultaneity: sw_s drops in the same cycle as the 3rd tick in WAIT1 -> state returns to ZERO, db_level stays 0, no db_rise.
REQ-031 Reset mid-wait: assert rst after 2 ticks in WAIT1 -> all outputs 0 at once; after release with sw_in=1, db_rise only after 3 further counted ticks.
REQ-032 Parameter edge: with STABLE_TICKS=1, db_level follows sw_s on the first tick counted after entering WAIT1.
